// File: rtl/esp8266_cmd_seq.sv
// esp8266_cmd_seq: streams the AT-command ROM to uart_tx over valid/ready,
// with an idle gap between commands and an optional loop mode.
module esp8266_cmd_seq #(
  parameter int ROM_LEN    = 34,
  parameter int GAP_CYCLES = 2500,
  parameter int LOOP       = 0,
  parameter int CMD_W      = 4,
  parameter int ADDR_W     = 6
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic             Abort,
  input  logic             Tx_ready,
  output logic             Tx_valid,
  output logic [7:0]       Tx_data,
  output logic             Busy,
  output logic             Done,
  output logic [CMD_W-1:0] Cmd_idx
);

  localparam int G  = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
  localparam int GW = $clog2(G + 1);
  localparam logic [GW-1:0]     GAP_LAST = GW'(G - 1);
  localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(ROM_LEN - 1);

  // "AT+CIPMUX=1\r\n" then "AT+CIPSERVER=1,8080\r\n"
  localparam logic [7:0] ROM [0:33] = '{
    8'h41, 8'h54, 8'h2B, 8'h43, 8'h49, 8'h50, 8'h4D,
    8'h55, 8'h58, 8'h3D, 8'h31, 8'h0D, 8'h0A,
    8'h41, 8'h54, 8'h2B, 8'h43, 8'h49, 8'h50, 8'h53,
    8'h45, 8'h52, 8'h56, 8'h45, 8'h52, 8'h3D, 8'h31,
    8'h2C, 8'h38, 8'h30, 8'h38, 8'h30, 8'h0D, 8'h0A
  };

  function automatic logic [7:0] rom_byte(
    input logic [ADDR_W-1:0] a
  );
    if (a <= LAST) return ROM[a];
    return 8'h00;
  endfunction

  typedef enum logic [1:0] {
    IDLE, SEND, GAP, DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_nx;
  logic [GW-1:0]     gap_cnt;
  logic              restart;
  logic              hs;

  assign hs      = Tx_valid & Tx_ready;
  assign addr_nx = addr + 1'b1;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= IDLE;
      addr     <= '0;
      gap_cnt  <= '0;
      restart  <= 1'b0;
      Cmd_idx  <= '0;
      Tx_valid <= 1'b0;
      Tx_data  <= 8'h00;
      Busy     <= 1'b0;
      Done     <= 1'b0;
    end else if (Abort) begin
      state    <= IDLE;
      addr     <= '0;
      gap_cnt  <= '0;
      restart  <= 1'b0;
      Cmd_idx  <= '0;
      Tx_valid <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
    end else begin
      Done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (Start) begin
            state    <= SEND;
            addr     <= '0;
            Cmd_idx  <= '0;
            restart  <= 1'b0;
            Tx_valid <= 1'b1;
            Tx_data  <= rom_byte('0);
            Busy     <= 1'b1;
          end
        end
        SEND: begin
          if (hs) begin
            if (Tx_data != 8'h0A) begin
              addr    <= addr_nx;
              Tx_data <= rom_byte(addr_nx);
            end else begin
              Tx_valid <= 1'b0;
              gap_cnt  <= '0;
              if (addr == LAST) begin
                state <= DONE;
                Done  <= 1'b1;
              end else begin
                state <= GAP;
              end
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state    <= SEND;
            gap_cnt  <= '0;
            Tx_valid <= 1'b1;
            restart  <= 1'b0;
            // a gap that follows DONE rewinds to the first command
            if (restart) begin
              addr    <= '0;
              Cmd_idx <= '0;
              Tx_data <= rom_byte('0);
            end else begin
              addr    <= addr_nx;
              Cmd_idx <= Cmd_idx + 1'b1;
              Tx_data <= rom_byte(addr_nx);
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        DONE: begin
          if (LOOP != 0) begin
            state   <= GAP;
            gap_cnt <= '0;
            restart <= 1'b1;
          end else begin
            state <= IDLE;
            Busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_esp8266_cmd_seq.sv
// Bench for esp8266_cmd_seq: stream-level reference model feeding a
// per-cycle scoreboard, plus directed checks and a looping instance.
module tb_esp8266_cmd_seq;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       Start, Abort, Tx_ready;
  logic       Tx_valid, Busy, Done;
  logic [7:0] Tx_data;
  logic [3:0] Cmd_idx;

  logic       start2;
  logic       v2, b2, dn2;
  logic [7:0] d2;
  logic [3:0] c2;

  always #5 Clk = ~Clk;

  esp8266_cmd_seq dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Abort(Abort),
    .Tx_ready(Tx_ready), .Tx_valid(Tx_valid), .Tx_data(Tx_data),
    .Busy(Busy), .Done(Done), .Cmd_idx(Cmd_idx)
  );

  esp8266_cmd_seq #(.LOOP(1), .GAP_CYCLES(0)) dut2 (
    .Clk(Clk), .Rst_n(Rst_n), .Start(start2), .Abort(1'b0),
    .Tx_ready(1'b1), .Tx_valid(v2), .Tx_data(d2),
    .Busy(b2), .Done(dn2), .Cmd_idx(c2)
  );

  localparam int G = 2500;
  string ROM_S = "AT+CIPMUX=1\r\nAT+CIPSERVER=1,8080\r\n";

  int n_chk = 0;
  int n_pass = 0;
  int hs_run = 0;
  bit rnd = 0;
  bit rnd_start = 0;
  bit d2_done = 0;

  task automatic check(input bit ok, input string nm,
                       input logic [31:0] act,
                       input logic [31:0] req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, req);
  endtask

  typedef struct packed {
    logic [3:0] c;
    logic [7:0] x;
  } item_t;

  typedef struct packed {
    logic       v;
    logic       b;
    logic       d;
    logic [3:0] c;
    logic [7:0] x;
  } rec_t;

  item_t pend[$];
  rec_t  exp_q[$];
  bit    m_valid = 0, m_busy = 0, m_done = 0;
  int    m_gap = 0;

  // reference model: the byte stream, gaps and completion
  always @(negedge Clk) begin
    rec_t  r;
    item_t h;
    bit    nv, nb, nd;
    r = '0;
    if (Rst_n) begin
      r.v = m_valid;
      r.b = m_busy;
      r.d = m_done;
      if (m_valid && pend.size() > 0) begin
        r.c = pend[0].c;
        r.x = pend[0].x;
      end
    end
    exp_q.push_back(r);
    if (!Rst_n || Abort) begin
      pend.delete();
      m_valid = 0; m_busy = 0; m_done = 0; m_gap = 0;
    end else begin
      nv = m_valid; nb = m_busy; nd = 0;
      if (m_done) nb = 0;
      if (!m_busy && Start) begin
        int c;
        c = 0;
        for (int i = 0; i < ROM_S.len(); i++) begin
          item_t it;
          it.x = ROM_S[i];
          it.c = 4'(c);
          pend.push_back(it);
          if (ROM_S[i] == 8'h0A) c++;
        end
        nv = 1; nb = 1;
      end else if (m_valid && Tx_ready) begin
        h = pend.pop_front();
        if (h.x == 8'h0A) begin
          nv = 0;
          if (pend.size() == 0) nd = 1;
          else m_gap = G;
        end
      end else if (m_gap > 0) begin
        m_gap--;
        if (m_gap == 0) nv = 1;
      end
      m_valid = nv; m_busy = nb; m_done = nd;
    end
  end

  // monitor: compare every cycle against the model
  always @(negedge Clk) begin
    rec_t r, a;
    #1;
    if (exp_q.size() == 0) begin
      check(1'b0, "sb_empty", 32'd0, 32'd1);
    end else begin
      r = exp_q.pop_front();
      a.v = Tx_valid; a.b = Busy; a.d = Done;
      a.c = r.v ? Cmd_idx : 4'd0;
      a.x = r.v ? Tx_data : 8'd0;
      check(a == r, "cycle", 32'(a), 32'(r));
    end
    if (Rst_n && !Abort && Tx_valid && Tx_ready) hs_run++;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic tick1();
    tick();
    if (rnd) Tx_ready = ($urandom_range(0, 3) != 0);
    Start = rnd_start && ($urandom_range(0, 99) == 0);
  endtask

  task automatic wait_done1(input int lim, input string nm);
    bit found;
    found = 0;
    for (int c = 0; c < lim; c++) begin
      if (Done) begin
        found = 1;
        break;
      end
      tick1();
    end
    check(found, nm, 32'(found), 32'd1);
  endtask

  task automatic check_reset(input string nm);
    check(!Tx_valid, {nm, "_valid"}, 32'(Tx_valid), 32'd0);
    check(Tx_data == 8'h00, {nm, "_data"}, 32'(Tx_data), 32'd0);
    check(!Busy, {nm, "_busy"}, 32'(Busy), 32'd0);
    check(!Done, {nm, "_done"}, 32'(Done), 32'd0);
    check(Cmd_idx == 4'd0, {nm, "_cmd"}, 32'(Cmd_idx), 32'd0);
  endtask

  task automatic dut2_run();
    int  n;
    bit  found;
    start2 = 1;
    tick();
    start2 = 0;
    for (int r = 0; r < 3; r++) begin
      n = 0;
      found = 0;
      for (int c = 0; c < 200; c++) begin
        if (dn2) begin
          found = 1;
          break;
        end
        if (v2) n++;
        tick();
      end
      check(found, "loop_done", 32'(found), 32'd1);
      check(n == 34, "loop_bytes", 32'(n), 32'd34);
      tick();
      check(!v2 && b2, "loop_gap", {30'd0, v2, b2}, 32'd1);
      tick();
      check(v2 && d2 == 8'h41 && c2 == 4'd0, "loop_restart",
            {19'd0, v2, c2, d2}, {19'd0, 1'b1, 4'd0, 8'h41});
    end
    d2_done = 1;
  endtask

  initial begin
    Rst_n = 0; Start = 0; Abort = 0; Tx_ready = 1; start2 = 0;
    #12;
    check_reset("reset");
    tick();
    Rst_n = 1;
    fork
      dut2_run();
    join_none
    repeat (3) tick1();
    check(!Busy, "idle_wait", 32'(Busy), 32'd0);

    hs_run = 0;
    Start = 1;
    tick1();
    check(Tx_valid && Tx_data == 8'h41, "first_byte",
          32'(Tx_data), 32'h41);
    for (int i = 0; i < 10; i++) begin
      if (Tx_valid && Tx_data == 8'h2B) break;
      tick1();
    end
    check(Tx_data == 8'h2B, "reach_2B", 32'(Tx_data), 32'h2B);
    Tx_ready = 0;
    repeat (5) tick1();
    check(Tx_valid && Tx_data == 8'h2B, "hold_2B",
          {23'd0, Tx_valid, Tx_data}, {23'd0, 1'b1, 8'h2B});
    Tx_ready = 1;
    tick1();
    check(Tx_data == 8'h43, "after_2B", 32'(Tx_data), 32'h43);
    repeat (20) tick1();
    Start = 1;
    tick1();
    wait_done1(6000, "done_run1");
    check(hs_run == 34, "hs_total", 32'(hs_run), 32'd34);
    tick1();
    check(!Busy && !Done, "busy_after_done", {30'd0, Busy, Done}, 32'd0);

    Start = 1; Abort = 1;
    tick1();
    Abort = 0;
    check(!Busy && !Tx_valid, "abort_beats_start",
          {30'd0, Busy, Tx_valid}, 32'd0);

    rnd = 1;
    hs_run = 0;
    Start = 1;
    tick1();
    for (int c = 0; c < 8000; c++) begin
      if (hs_run == 20 && Tx_valid) break;
      tick1();
    end
    check(hs_run == 20, "reach_addr20", 32'(hs_run), 32'd20);
    Abort = 1;
    tick1();
    Abort = 0;
    check(!Tx_valid, "abort_valid", 32'(Tx_valid), 32'd0);
    check(!Busy, "abort_busy", 32'(Busy), 32'd0);
    check(Cmd_idx == 4'd0, "abort_cmd", 32'(Cmd_idx), 32'd0);
    hs_run = 0;
    Start = 1;
    tick1();
    check(Tx_valid && Tx_data == 8'h41, "restart_41",
          32'(Tx_data), 32'h41);

    for (int c = 0; c < 8000; c++) begin
      if (hs_run >= 13 && !Tx_valid) break;
      tick1();
    end
    check(hs_run == 13, "reach_gap", 32'(hs_run), 32'd13);
    repeat (100) tick1();
    #2 Rst_n = 0;
    #1 check_reset("async_reset");
    @(posedge Clk);
    #1 Rst_n = 1;
    repeat (5) tick1();
    check(!Busy && !Tx_valid, "idle_after_reset",
          {30'd0, Busy, Tx_valid}, 32'd0);

    rnd_start = 1;
    for (int r = 0; r < 3; r++) begin
      Start = 1;
      tick1();
      wait_done1(8000, "done_rand");
      tick1();
    end
    rnd_start = 0;
    Start = 0;

    for (int i = 0; i < 1000 && !d2_done; i++) tick();
    check(d2_done, "loop_finished", 32'(d2_done), 32'd1);
    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
